// File: rtl/hazard_scoreboard.sv
// Consumer-side hazard unit for the 5-stage MIPS pipeline: tracks E/M/W writer
// records, produces D-stage stall and forward selects, and owns the mult/div busy timer.
module hazard_scoreboard #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_uses_md,
  input  logic       e_md_start,
  input  logic       e_md_div,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } rec_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);
  localparam logic [1:0] TUSE_NONE = 2'd3;

  rec_t       e_q, m_q, w_q;
  rec_t       e_d, m_d, w_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       data_stall, md_busy_raw, stall_raw;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input rec_t r, input logic [4:0] s, input logic [1:0] tuse);
    return (r.dst == s) && (s != 5'd0) && (tuse != TUSE_NONE);
  endfunction

  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse);
    return (hit(e_q, s, tuse) && (e_q.tnew > tuse)) ||
           (hit(m_q, s, tuse) && (m_q.tnew > tuse));
  endfunction

  // The newest matching record decides; a not-yet-ready newest match must
  // never fall through to an older, stale copy of the same register.
  function automatic logic [1:0] src_fwd(input logic [4:0] s, input logic [1:0] tuse);
    if (hit(e_q, s, tuse)) return (e_q.tnew == 2'd0) ? 2'd1 : 2'd0;
    if (hit(m_q, s, tuse)) return (m_q.tnew == 2'd0) ? 2'd2 : 2'd0;
    if (hit(w_q, s, tuse)) return (w_q.tnew == 2'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    data_stall  = 1'b0;
    md_busy_raw = 1'b0;
    stall_raw   = 1'b0;
    stall       = 1'b0;
    fwd_rs      = 2'd0;
    fwd_rt      = 2'd0;
    md_busy     = 1'b0;

    data_stall  = src_stall(d_rs, d_tuse_rs) || src_stall(d_rt, d_tuse_rt);
    md_busy_raw = e_md_start || (md_cnt_q != 4'd0);
    stall_raw   = data_stall || (d_uses_md && md_busy_raw);

    // Outputs read as idle the instant reset asserts, whatever the inputs do.
    if (reset) begin
      stall   = stall_raw;
      fwd_rs  = src_fwd(d_rs, d_tuse_rs);
      fwd_rt  = src_fwd(d_rt, d_tuse_rt);
      md_busy = md_busy_raw;
    end
  end

  always_comb begin
    e_d = stall_raw ? '0 : rec_t'{dst: d_dst, tnew: d_tnew};
    m_d = rec_t'{dst: e_q.dst, tnew: dec_sat(e_q.tnew)};
    w_d = rec_t'{dst: m_q.dst, tnew: 2'd0};
    if (flush) begin
      e_d = '0;
      m_d = '0;
      w_d = '0;
    end

    // The mult/div timer ignores flush and stall: a started operation completes.
    if (e_md_start)              md_cnt_d = e_md_div ? DIV_LD : MULT_LD;
    else if (md_cnt_q != 4'd0)   md_cnt_d = md_cnt_q - 4'd1;
    else                         md_cnt_d = md_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all records update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      md_cnt_q <= 4'd0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer-side hazard unit for the 5-stage MIPS pipeline.
- Receives per-instruction Tuse (when D needs rs/rt) plus dest/Tnew from the decoder. Tracks in-flight writers in E/M/W records whose Tnew counts down as they advance.
- Compares each D-stage source against those records; outputs stall and D-stage forward selects.
- Also owns the mult/div busy countdown that stalls HI/LO users.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded on a mult/multu start (1..15).
- DIV_CYCLES, 10, busy cycles loaded on a div/divu start (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; all state cleared while low.
- d_rs  input  5  D-stage rs index.
- d_rt  input  5  D-stage rt index.
- d_tuse_rs  input  2  cycles until rs is consumed (0..2); 3 = rs not read.
- d_tuse_rt  input  2  same for rt.
- d_dst  input  5  D-stage destination register; 0 = no write.
- d_tnew  input  2  Tnew the instruction will have on entering E (load 2, ALU/mfhi/mflo/mfc0 1, else 0).
- d_uses_md  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_md_start  input  1  E-stage instruction starts mult/div this cycle.
- e_md_div  input  1  with e_md_start: 1 = div, 0 = mult.
- flush  input  1  exception/eret flush of E/M/W.
- stall  output  1  freeze PC and D; insert bubble into E.
- fwd_rs  output  2  D rs source: 0 regfile, 1 E, 2 M, 3 W.
- fwd_rt  output  2  same for rt.
- md_busy  output  1  mult/div unit busy.

Behaviour:
- Records: E, M and W each hold {dst[4:0], tnew[1:0]}. Reset (reset low) sets all to {0,0} and md_cnt to 0.
- Reset values: stall=0, fwd_rs=fwd_rt=0, md_busy=0.
- Each posedge, records update as follows:
  - Priority: flush > stall > normal.
  - Flush: E, M and W cleared to {0,0}.
  - Stall: E <= {0,0} (bubble); M <= E; W <= M.
  - Normal: E <= {d_dst, d_tnew}; M <= E; W <= M.
  - Tnew rule: tnew decrements by 1 on each E->M and M->W move, saturating at 0. Decrement is applied to the moved value only.
  - W is always presented with tnew 0 (result ready).
- Matching: a record "matches" source s when record.dst == s, s != 0, and the corresponding tuse != 3.
- Data stall (combinational): stall for source s when an E match has E.tnew > tuse_s, or an M match has M.tnew > tuse_s. Checked for both rs and rt.
- Forwarding (combinational):
  - Newest match wins: E > M > W.
  - Select 1/2/3 only when the winning record has tnew == 0; otherwise 0.
  - If the newest match has tnew > 0, select is 0 and the consumer picks the value up later stage. Never fall through to an older record.
- Mult/div counter:
  - md_cnt[3:0]: on e_md_start, load MULT_CYCLES or DIV_CYCLES. Otherwise, if nonzero, decrement by 1.
  - md_busy = e_md_start | (md_cnt != 0).
  - MD stall = d_uses_md & md_busy.
  - flush does not affect md_cnt; an operation already started completes.
- stall = data stall | MD stall. Stall has no effect on md_cnt.
- Reset asserted mid-operation: records and md_cnt clear immediately, asynchronously; outputs return to reset values in the same cycle.
- d_dst == 0 never creates a hazard or forward.

Test Plan:
- lw $1 followed by addu $2,$1,$3 (tuse_rs=1): stall=1 for exactly 1 cycle. Next cycle M={1,1} gives no stall and fwd_rs=0; when lw reaches W, a consumer with tuse 0 sees fwd_rs=3.
- addu $4 then beq on $4 (tuse 0): E={4,1} gives stall=1 for 1 cycle. Next cycle M={4,0} gives stall=0, fwd_rs=2.
- ori $5 then sw with rt=$5 (tuse_rt=2): no stall. fwd_rt=0 in D; 1 cycle later that consumer is in E with the producer in M.
- Same register in E and M, E.tnew=1, tuse 1: stall=0, fwd_rs=0 (E masks M). The $0 destination variant gives no stall and fwd 0.
- e_md_start with e_md_div=1, then mflo in D: md_busy high for 11 cycles (start + 10). mflo stalls throughout and is released when md_cnt reaches 0. A flush asserted mid-count leaves md_cnt counting.
- Assert reset low mid-stall with lw in E: stall drops to 0 asynchronously; all records {0,0}; md_busy=0.
